// File: rtl/fp_issue_sequencer.sv
// rtl/fp_issue_sequencer.sv - COP1 add/sub/mul issue sequencer for a shared multi-cycle FP unit
module fp_issue_sequencer #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_op,
    input  logic [4:0]  issue_fd,
    input  logic [4:0]  issue_fs,
    input  logic [4:0]  issue_ft,
    output logic        unit_start,
    output logic [1:0]  unit_op,
    output logic [4:0]  unit_fs,
    output logic [4:0]  unit_ft,
    input  logic [31:0] unit_result,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        illegal_op
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [3:0] ADD_CNT = 4'(ADD_LAT);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;
    logic [4:0]  fs_q, ft_q, fd_q;
    logic [31:0] wb_data_q;
    logic        start_q, illegal_q;
    logic        hz, ready_raw, accept;

    assign hz = (issue_fs == fd_q) || (issue_ft == fd_q);

    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            IDLE:    ready_raw = 1'b1;
            WB:      ready_raw = !hz;
            default: ready_raw = 1'b0;
        endcase
    end

    assign issue_ready = ready_raw && !rst && !flush;
    assign accept      = issue_valid && issue_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op_q      <= 2'd0;
            fs_q      <= 5'd0;
            ft_q      <= 5'd0;
            fd_q      <= 5'd0;
            wb_data_q <= 32'd0;
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE, WB: begin
                    if (accept && issue_op == 2'b11) begin
                        illegal_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (accept) begin
                        op_q    <= issue_op;
                        fs_q    <= issue_fs;
                        ft_q    <= issue_ft;
                        fd_q    <= issue_fd;
                        cnt_q   <= (issue_op == 2'b10) ? MUL_CNT : ADD_CNT;
                        start_q <= 1'b1;
                        state_q <= EXEC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    // A flushed op drops its result; the unit is simply not listened to.
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            wb_data_q <= unit_result;
                            state_q   <= WB;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign unit_start = start_q;
    assign unit_op    = op_q;
    assign unit_fs    = fs_q;
    assign unit_ft    = ft_q;
    assign wb_en      = (state_q == WB) && !flush;
    assign wb_addr    = fd_q;
    assign wb_data    = wb_data_q;
    assign busy       = (state_q != IDLE);
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// tb/tb_fp_issue_sequencer.sv - directed and random bench for fp_issue_sequencer with timeline reference model
module tb_fp_issue_sequencer;

    localparam int ADD_LAT = 3;
    localparam int MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_op = 2'd0;
    logic [4:0]  issue_fd = 5'd0, issue_fs = 5'd0, issue_ft = 5'd0;
    logic [31:0] unit_result = 32'd0;
    logic        issue_ready, unit_start, wb_en, busy, illegal_op;
    logic [1:0]  unit_op;
    logic [4:0]  unit_fs, unit_ft, wb_addr;
    logic [31:0] wb_data;

    fp_issue_sequencer #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_fd(issue_fd), .issue_fs(issue_fs), .issue_ft(issue_ft),
        .unit_start(unit_start), .unit_op(unit_op), .unit_fs(unit_fs), .unit_ft(unit_ft),
        .unit_result(unit_result), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    // Reference: an op presented in cycle A with latency L executes in A+1..A+L
    // and writes back in A+L+1; the result is whatever the unit drove in A+L.
    bit          m_active = 1'b0;
    int          m_acc = 0, m_lat = 0, m_ill = -10;
    logic [1:0]  m_op = 2'd0;
    logic [4:0]  m_fd = 5'd0, m_fs = 5'd0, m_ft = 5'd0;
    logic [31:0] m_res = 32'd0;
    bit          exp_acc = 1'b0;
    bit          last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        int  d;
        bit  in_exec, in_wb, exp_ready;
        d       = cyc - m_acc;
        in_exec = m_active && d >= 1 && d <= m_lat;
        in_wb   = m_active && d == m_lat + 1;
        if (!m_active)  exp_ready = !flush;
        else if (in_wb) exp_ready = !flush && issue_fs != m_fd && issue_ft != m_fd;
        else            exp_ready = 1'b0;
        chk("issue_ready", issue_ready, exp_ready);
        chk("busy", busy, m_active);
        chk("unit_start", unit_start, in_exec && d == 1);
        chk("wb_en", wb_en, in_wb && !flush);
        chk("illegal_op", illegal_op, cyc == m_ill + 1);
        if (in_exec || in_wb) begin
            chk("unit_op", unit_op, m_op);
            chk("unit_fs", unit_fs, m_fs);
            chk("unit_ft", unit_ft, m_ft);
        end
        if (in_wb) begin
            chk("wb_addr", wb_addr, m_fd);
            chk("wb_data", wb_data, m_res);
        end
        exp_acc = issue_valid && exp_ready;
    endtask

    task automatic update_model();
        int d;
        d = cyc - m_acc;
        if (m_active && d == m_lat && !flush) m_res = unit_result;
        if (m_active && (flush || d == m_lat + 1)) m_active = 1'b0;
        if (exp_acc) begin
            if (issue_op == 2'b11) begin
                m_ill = cyc;
            end else begin
                m_active = 1'b1;
                m_acc    = cyc;
                m_lat    = (issue_op == 2'b10) ? MUL_LAT : ADD_LAT;
                m_op     = issue_op;
                m_fd     = issue_fd;
                m_fs     = issue_fs;
                m_ft     = issue_ft;
            end
        end
        last_acc = exp_acc;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        cyc++;
        #1;
    endtask

    task automatic set_in(input bit v, input logic [1:0] op, input logic [4:0] fd,
                          input logic [4:0] fs, input logic [4:0] ft);
        issue_valid = v;
        issue_op    = op;
        issue_fd    = fd;
        issue_fs    = fs;
        issue_ft    = ft;
    endtask

    task automatic issue_and_wait(input logic [1:0] op, input logic [4:0] fd, input logic [4:0] fs,
                                  input logic [4:0] ft, output int acc_cyc);
        set_in(1'b1, op, fd, fs, ft);
        acc_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            run_cycle();
            if (last_acc) begin
                acc_cyc = cyc - 1;
                break;
            end
        end
        chk("accept_within_bound", acc_cyc >= 0, 1'b1);
        set_in(1'b0, 2'd0, 5'd0, 5'd31, 5'd31);
    endtask

    initial begin
        int a, b;
        #1;
        chk("rst_issue_ready", issue_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_unit_start", unit_start, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_unit_op", unit_op, 2'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_cycle();

        // add fd=3 fs=1 ft=2, result driven in the LAT-th EXEC cycle
        issue_and_wait(2'b00, 5'd3, 5'd1, 5'd2, a);
        run_cycle();
        run_cycle();
        unit_result = 32'h40400000;
        run_cycle();
        unit_result = 32'd0;
        chk("add_wb_en", wb_en, 1'b1);
        chk("add_wb_addr", wb_addr, 5'd3);
        chk("add_wb_data", wb_data, 32'h40400000);
        repeat (2) run_cycle();

        // mul writes back exactly MUL_LAT+1 cycles after presentation
        issue_and_wait(2'b10, 5'd7, 5'd4, 5'd6, a);
        repeat (MUL_LAT) run_cycle();
        chk("mul_wb_en", wb_en, 1'b1);
        chk("mul_wb_latency", cyc - a, MUL_LAT + 1);
        repeat (2) run_cycle();

        // RAW: sub reading the pending fd waits past WB; an independent sub goes in WB
        issue_and_wait(2'b00, 5'd5, 5'd1, 5'd2, a);
        issue_and_wait(2'b01, 5'd9, 5'd5, 5'd1, b);
        chk("raw_stall_accept", b - a, ADD_LAT + 2);
        repeat (ADD_LAT + 3) run_cycle();
        issue_and_wait(2'b00, 5'd5, 5'd1, 5'd2, a);
        issue_and_wait(2'b01, 5'd8, 5'd6, 5'd1, b);
        chk("nohz_accept_in_wb", b - a, ADD_LAT + 1);
        chk("b2b_unit_start", unit_start, 1'b1);
        repeat (ADD_LAT + 3) run_cycle();

        // flush in cycle 2 of an add, then a new op is accepted in cycle 3
        issue_and_wait(2'b00, 5'd10, 5'd1, 5'd2, a);
        run_cycle();
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        issue_and_wait(2'b00, 5'd11, 5'd3, 5'd4, b);
        chk("flush_reaccept", b - a, 3);
        repeat (ADD_LAT + 2) run_cycle();

        // flush in the WB cycle suppresses the write
        issue_and_wait(2'b00, 5'd12, 5'd1, 5'd2, a);
        repeat (ADD_LAT) run_cycle();
        flush = 1'b1;
        #1;
        chk("flush_wb_en", wb_en, 1'b0);
        run_cycle();
        flush = 1'b0;
        run_cycle();

        // reserved op
        issue_and_wait(2'b11, 5'd13, 5'd1, 5'd1, a);
        chk("illegal_pulse", illegal_op, 1'b1);
        chk("illegal_busy", busy, 1'b0);
        chk("illegal_start", unit_start, 1'b0);
        repeat (3) run_cycle();

        // asynchronous reset mid-EXEC
        issue_and_wait(2'b00, 5'd14, 5'd1, 5'd2, a);
        run_cycle();
        set_in(1'b1, 2'b00, 5'd15, 5'd1, 5'd2);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_unit_start", unit_start, 1'b0);
        chk("midrst_unit_fs", unit_fs, 5'd0);
        chk("midrst_wb_addr", wb_addr, 5'd0);
        chk("midrst_issue_ready", issue_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_held_ready", issue_ready, 1'b0);
        set_in(1'b0, 2'd0, 5'd0, 5'd31, 5'd31);
        rst = 1'b0;
        m_active = 1'b0;
        m_ill = -10;
        cyc++;
        repeat (6) run_cycle();

        // random traffic with a small register pool to provoke hazards
        for (int i = 0; i < 400; i++) begin
            flush       = ($urandom_range(0, 19) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_op    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue_fd    = 5'($urandom_range(0, 7));
            issue_fs    = 5'($urandom_range(0, 7));
            issue_ft    = 5'($urandom_range(0, 7));
            unit_result = $urandom;
            run_cycle();
        end
        flush = 1'b0;
        set_in(1'b0, 2'd0, 5'd0, 5'd31, 5'd31);
        repeat (8) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/fp_issue_sequencer.md
Name: fp_issue_sequencer

Overview:
- Sequences COP1 arithmetic (add.s/sub.s/mul.s) through a shared multi-cycle FP unit. Sits between decode (after the FP controller flags an FP op) and the FP register-file write port.
- Accepts one op at a time over a valid/ready handshake and launches it on the FP unit. Counts the per-op latency, then writes the result back.
- Stalls decode on RAW hazards against the in-flight destination register.

Parameters:
- ADD_LAT, 3: FP unit cycles for add/sub; legal range 1..15.
- MUL_LAT, 4: FP unit cycles for mul; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous abort of the in-flight op (branch/exception)
- issue_valid  input  1  decode presents an FP op
- issue_ready  output  1  sequencer accepts the op this cycle (combinational)
- issue_op  input  2  00 add, 01 sub, 10 mul, 11 reserved
- issue_fd  input  5  destination FP register
- issue_fs  input  5  source FP register 1
- issue_ft  input  5  source FP register 2
- unit_start  output  1  one-cycle launch pulse to the FP unit
- unit_op  output  2  latched op to the FP unit
- unit_fs  output  5  latched fs (FP regfile read address)
- unit_ft  output  5  latched ft (FP regfile read address)
- unit_result  input  32  FP unit result
- wb_en  output  1  FP regfile write enable
- wb_addr  output  5  write address (latched fd)
- wb_data  output  32  write data
- busy  output  1  state != IDLE
- illegal_op  output  1  one-cycle pulse when a reserved op is accepted

Behaviour:
- Reset (async):
  - state=IDLE, cnt=0.
  - unit_op/unit_fs/unit_ft/wb_addr/wb_data=0; unit_start, wb_en, illegal_op, busy=0.
  - issue_ready forced 0 while rst is high.
- States: IDLE, EXEC, WB.
- Accept: an op is accepted on a rising edge where issue_valid & issue_ready & !flush.
- Hazard: hz = (issue_fs==pend_fd | issue_ft==pend_fd), where pend_fd is the latched fd, checked only in EXEC/WB.
- issue_ready:
  - IDLE: 1.
  - EXEC: 0.
  - WB: !hz.
  - Always gated by !rst and !flush.
- IDLE/WB + accept, op!=11:
  - Latch op/fs/ft/fd.
  - Load cnt with ADD_LAT (op 00/01) or MUL_LAT (op 10).
  - Next state EXEC.
- IDLE/WB + accept, op==11: no launch; illegal_op=1 the next cycle; next state IDLE.
- WB without accept -> IDLE.
- EXEC:
  - unit_start=1 only in the first EXEC cycle; unit_op/fs/ft held stable throughout EXEC.
  - cnt decrements each cycle.
  - On the edge where cnt==1, capture unit_result into wb_data and go to WB.
  - EXEC lasts exactly LAT cycles; the FP unit must present its result in the LAT-th EXEC cycle.
- WB: wb_en = (state==WB) & !flush; wb_addr = latched fd.
- Latency: accept edge at cycle 0 -> unit_start in cycle 1 -> wb_en in cycle LAT+1.
- Back-to-back: an op accepted during WB launches in the following cycle, giving a throughput of one op per LAT+1 cycles.
- Write-after-write: with a single outstanding op, writes stay in order; no WAW check needed.
- Flush:
  - Any state -> IDLE at the next edge. Suppresses wb_en combinationally in the same cycle and blocks acceptance in that cycle.
  - Flush during EXEC: unit_start not re-issued; the unit result is ignored.
- Mid-op reset: immediate return to reset values; no writeback.
- The counter is 4 bits wide; LAT=1 gives a single EXEC cycle in which unit_start is high and the result is captured.

Test Plan:
- Add, no hazard: add fd=3 fs=1 ft=2, accepted at cycle 0 -> unit_start in cycle 1, busy 1..4, wb_en=1 in cycle 4 with wb_addr=3 and wb_data=0x40400000 (unit_result driven in cycle 3).
- Mul latency: mul fd=7 -> wb_en exactly in cycle 5; issue_ready=0 in cycles 1..4.
- RAW stall: add fd=5 in flight, then a sub with fs=5 waiting -> issue_ready=0 through WB; accepted in the first IDLE cycle. A sub with fs=6 is instead accepted during WB and gets unit_start the cycle after.
- Flush: flush asserted in cycle 2 of an add -> no wb_en, state IDLE in cycle 3, a new op accepted in cycle 3. Flush in the WB cycle -> wb_en stays 0.
- Reserved op: issue_op=11 in IDLE -> accepted, illegal_op pulse in cycle 1, no unit_start, no wb_en, busy stays 0.
- Reset mid-EXEC: rst asserted asynchronously in cycle 2 -> all outputs 0 immediately, issue_ready 0 while rst is high, no writeback after release.
